// File: rtl/note_sequencer.sv
// Note pattern sequencer feeding the envelope generator: steps a small
// programmable pattern, strobing note_on/note_off and waiting for release.
module note_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DURW  = 16
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [6:0]      wr_note,
   input  logic [DURW-1:0] wr_dur,
   input  logic [AW:0]     len,
   input  logic            loop_en,
   input  logic            start,
   input  logic            stop,
   input  logic            env_busy,
   input  logic            env_done,
   output logic            note_on,
   output logic            note_off,
   output logic [6:0]      note_code,
   output logic [AW-1:0]   step_idx,
   output logic            running,
   output logic            seq_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TRIG = 3'd1;
   localparam logic [2:0] S_GATE = 3'd2;
   localparam logic [2:0] S_RELW = 3'd3;
   localparam logic [2:0] S_STEP = 3'd4;

   logic [6+DURW:0] mem_q [DEPTH];
   logic [6+DURW:0] rd_ent;
   logic [6:0]      rd_note;
   logic [DURW-1:0] rd_dur;

   logic [2:0]      state_q, state_d;
   logic [AW-1:0]   step_q, step_d;
   logic [DURW-1:0] cnt_q, cnt_d;
   logic [DURW-1:0] dur_q, dur_d;
   logic [6:0]      note_q, note_d;
   logic            abort_q, abort_d;
   logic            on, off, done, last;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= {wr_note, wr_dur};
   end

   // Asynchronous read: a write in the trigger cycle lands after the sample
   assign rd_ent  = mem_q[step_q];
   assign rd_note = rd_ent[DURW+6:DURW];
   assign rd_dur  = rd_ent[DURW-1:0];
   assign last    = ({1'b0, step_q} + (AW+1)'(1)) >= len;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      dur_d   = dur_q;
      note_d  = note_q;
      abort_d = abort_q;
      on      = 1'b0;
      off     = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop && len != '0) begin
               step_d  = '0;
               abort_d = 1'b0;
               state_d = S_TRIG;
            end
         end
         S_TRIG: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (rd_dur == '0) begin
               state_d = S_STEP;
            end else if (!env_busy) begin
               on      = 1'b1;
               note_d  = rd_note;
               dur_d   = rd_dur;
               cnt_d   = DURW'(1);
               state_d = S_GATE;
            end
         end
         S_GATE: begin
            if (stop || cnt_q == dur_q) begin
               off     = 1'b1;
               abort_d = stop;
               state_d = S_RELW;
            end else begin
               cnt_d = cnt_q + DURW'(1);
            end
         end
         S_RELW: begin
            if (stop) abort_d = 1'b1;
            if (env_done) state_d = (abort_q || stop) ? S_IDLE : S_STEP;
         end
         S_STEP: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (last && loop_en) begin
               step_d  = '0;
               state_d = S_TRIG;
            end else if (last) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               step_d  = step_q + AW'(1);
               state_d = S_TRIG;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         dur_q   <= '0;
         note_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         dur_q   <= dur_d;
         note_q  <= note_d;
         abort_q <= abort_d;
      end
   end

   assign note_on   = on;
   assign note_off  = off;
   assign seq_done  = done;
   assign running   = state_q != S_IDLE;
   assign note_code = on ? rd_note : note_q;
   assign step_idx  = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: event-level play model plus a reactive
// envelope model, directed scenarios and randomized patterns.
module tb_note_sequencer;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int DURW  = 16;

   logic            clk = 1'b0;
   logic            rst_b, wr_en, loop_en, start, stop, env_busy, env_done;
   logic [AW-1:0]   wr_addr;
   logic [6:0]      wr_note;
   logic [DURW-1:0] wr_dur;
   logic [AW:0]     len;
   logic            note_on, note_off, running, seq_done;
   logic [6:0]      note_code;
   logic [AW-1:0]   step_idx;

   always #5 clk = ~clk;

   note_sequencer #(.DEPTH(DEPTH), .AW(AW), .DURW(DURW)) dut (
      .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_note(wr_note), .wr_dur(wr_dur), .len(len), .loop_en(loop_en),
      .start(start), .stop(stop), .env_busy(env_busy), .env_done(env_done),
      .note_on(note_on), .note_off(note_off), .note_code(note_code),
      .step_idx(step_idx), .running(running), .seq_done(seq_done)
   );

   // kind: 0 = note_on, 1 = note_off, 2 = seq_done
   typedef struct packed {
      logic [1:0]    k;
      logic [31:0]   c;
      logic [6:0]    n;
      logic [AW-1:0] s;
   } ev_t;

   ev_t act_q[$];
   ev_t exp_q[$];
   int vectors = 0, miscompares = 0, cyc = 0, overlap = 0;
   int start_at = -1, stop_at = -1, busy_until = 0, done_at = -1;
   int wr_at = -1, rst_at = -1, rst_until = 0, rel = 1;
   logic [AW-1:0]   pend_a;
   logic [6:0]      pend_n;
   logic [DURW-1:0] pend_d;
   logic [6:0]      mdl_pn[DEPTH];
   int              mdl_pd[DEPTH];
   logic [6:0]      mdl_note;

   function automatic ev_t mk(input int k, input int c, input logic [6:0] n,
                              input int s);
      ev_t e;
      e.k = k[1:0];
      e.c = c;
      e.n = n;
      e.s = s[AW-1:0];
      return e;
   endfunction

   // One clock window: drive at posedge+1, observe at negedge
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      rst_b    = !(cyc < rst_until || cyc == rst_at);
      start    = (cyc == start_at);
      stop     = (cyc == stop_at);
      env_busy = (cyc < busy_until);
      env_done = (cyc == done_at);
      wr_en    = (cyc == wr_at);
      if (cyc == wr_at) begin
         wr_addr = pend_a;
         wr_note = pend_n;
         wr_dur  = pend_d;
      end
      @(negedge clk);
      if (note_on && note_off) overlap++;
      if (note_on) act_q.push_back(mk(0, cyc, note_code, int'(step_idx)));
      if (note_off) begin
         act_q.push_back(mk(1, cyc, note_code, int'(step_idx)));
         done_at = cyc + rel;
      end
      if (seq_done) act_q.push_back(mk(2, cyc, note_code, int'(step_idx)));
   endtask

   task automatic write_entry(input int a, input int n, input int d);
      pend_a = a[AW-1:0];
      pend_n = n[6:0];
      pend_d = d[DURW-1:0];
      wr_at  = cyc + 1;
      tick();
      wr_at     = -1;
      mdl_pn[a] = n[6:0];
      mdl_pd[a] = d;
   endtask

   // Pattern entry as seen by a step sampled in window t
   function automatic void rd(input int i, input int t,
                              output logic [6:0] n, output int d);
      if (wr_at >= 0 && wr_at < t && i == int'(pend_a)) begin
         n = pend_n;
         d = int'(pend_d);
      end else begin
         n = mdl_pn[i];
         d = mdl_pd[i];
      end
   endfunction

   // Expected strobe timeline for a start issued in window s
   task automatic model(input int s, output int end_t);
      int t, i, d, ton, off, sw, l;
      bit ab;
      logic [6:0] nt;
      exp_q.delete();
      l = int'(len);
      end_t = s + 1;
      if (stop_at == s || l == 0) return;
      t = s + 1;
      i = 0;
      while (t < s + 5000) begin
         rd(i, t, nt, d);
         if (d == 0) begin
            if (stop_at == t) begin
               end_t = t + 1;
               return;
            end
            sw = t + 1;
         end else begin
            ton = (t < busy_until) ? busy_until : t;
            if (stop_at >= t && stop_at <= ton) begin
               end_t = stop_at + 1;
               return;
            end
            mdl_note = nt;
            exp_q.push_back(mk(0, ton, nt, i));
            ab  = stop_at > ton && stop_at <= ton + d;
            off = ab ? stop_at : ton + d;
            exp_q.push_back(mk(1, off, mdl_note, i));
            if (stop_at > off && stop_at <= off + rel) ab = 1'b1;
            if (ab) begin
               end_t = off + rel + 1;
               return;
            end
            sw = off + rel + 1;
         end
         if (stop_at == sw) begin
            end_t = sw + 1;
            return;
         end
         if (i >= l - 1) begin
            if (!loop_en) begin
               exp_q.push_back(mk(2, sw, mdl_note, i));
               end_t = sw + 1;
               return;
            end
            i = 0;
         end else begin
            i++;
         end
         t = sw + 1;
      end
      end_t = t;
   endtask

   task automatic play(input int l, input bit lp, input int r,
                       input int busy_len, input int stop_off);
      int end_t, lim;
      act_q.delete();
      len        = l[AW:0];
      loop_en    = lp;
      rel        = r;
      start_at   = cyc + 1;
      busy_until = (busy_len > 0) ? start_at + busy_len : 0;
      stop_at    = (stop_off >= 0) ? start_at + stop_off : -1;
      model(start_at, end_t);
      lim = ((end_t > stop_at) ? end_t : stop_at) + 4;
      while (cyc < lim) tick();
      start_at   = -1;
      stop_at    = -1;
      busy_until = 0;
      wr_at      = -1;
      done_at    = -1;
   endtask

   task automatic test_reset();
      rst_until = 3;
      repeat (4) tick();
      vectors++;
      if (note_on !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_on got %b want 0", note_on);
      end
      vectors++;
      if (note_off !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_off got %b want 0", note_off);
      end
      vectors++;
      if (running !== 1'b0 || seq_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_run got %b/%b want 0/0", running, seq_done);
      end
      vectors++;
      if (note_code !== 7'd0 || step_idx !== '0) begin
         miscompares++;
         $display("FAIL reset_code got %0d/%0d want 0/0", note_code, step_idx);
      end
   endtask

   task automatic test_basic();
      write_entry(0, 60, 5);
      write_entry(1, 64, 3);
      play(2, 1'b0, 4, 0, -1);
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL basic_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL basic_ev%0d got k%0d c%0d n%0d s%0d want k%0d c%0d n%0d s%0d",
                     i, act_q[i].k, act_q[i].c, act_q[i].n, act_q[i].s,
                     exp_q[i].k, exp_q[i].c, exp_q[i].n, exp_q[i].s);
         end
      end
      if (act_q.size() >= 2) begin
         vectors++;
         if (act_q[0].n !== 7'd60 || act_q[1].c - act_q[0].c !== 5) begin
            miscompares++;
            $display("FAIL basic_gate got n%0d gap%0d want n60 gap5",
                     act_q[0].n, act_q[1].c - act_q[0].c);
         end
      end
      vectors++;
      if (running !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_run got %b want 0", running);
      end
   endtask

   task automatic test_busy();
      int s0;
      s0 = cyc + 1;
      play(2, 1'b0, 2, 10, -1);
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL busy_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL busy_ev%0d got k%0d c%0d n%0d want k%0d c%0d n%0d",
                     i, act_q[i].k, act_q[i].c, act_q[i].n,
                     exp_q[i].k, exp_q[i].c, exp_q[i].n);
         end
      end
      if (act_q.size() > 0) begin
         vectors++;
         if (act_q[0].c !== s0 + 10) begin
            miscompares++;
            $display("FAIL busy_first_on got %0d want %0d", act_q[0].c, s0 + 10);
         end
      end
   endtask

   task automatic test_rest_loop();
      write_entry(0, 50, 2);
      write_entry(1, 99, 0);
      write_entry(2, 52, 1);
      play(3, 1'b1, 2, 0, 45);
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL loop_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL loop_ev%0d got k%0d c%0d n%0d s%0d want k%0d c%0d n%0d s%0d",
                     i, act_q[i].k, act_q[i].c, act_q[i].n, act_q[i].s,
                     exp_q[i].k, exp_q[i].c, exp_q[i].n, exp_q[i].s);
         end
      end
      if (act_q.size() >= 7) begin
         vectors++;
         if (act_q[2].n !== 7'd52 || act_q[4].n !== 7'd50 || act_q[6].n !== 7'd52) begin
            miscompares++;
            $display("FAIL loop_notes got %0d,%0d,%0d want 52,50,52",
                     act_q[2].n, act_q[4].n, act_q[6].n);
         end
      end
   endtask

   task automatic test_stop_gate();
      int s0;
      write_entry(0, 40, 20);
      s0 = cyc + 1;
      play(1, 1'b0, 3, 0, 3);
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL stop_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL stop_ev%0d got k%0d c%0d want k%0d c%0d",
                     i, act_q[i].k, act_q[i].c, exp_q[i].k, exp_q[i].c);
         end
      end
      if (act_q.size() >= 2) begin
         vectors++;
         if (act_q[1].k !== 2'd1 || act_q[1].c !== s0 + 3) begin
            miscompares++;
            $display("FAIL stop_off got k%0d c%0d want k1 c%0d",
                     act_q[1].k, act_q[1].c, s0 + 3);
         end
      end
      vectors++;
      if (running !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_run got %b want 0", running);
      end
   endtask

   task automatic test_reset_mid();
      act_q.delete();
      len      = 1;
      loop_en  = 1'b0;
      rel      = 3;
      start_at = cyc + 1;
      rst_at   = cyc + 5;
      while (cyc < rst_at + 1) tick();
      vectors++;
      if ({note_on, note_off, seq_done, running} !== 4'b0) begin
         miscompares++;
         $display("FAIL rstmid_strobes got %b want 0000",
                  {note_on, note_off, seq_done, running});
      end
      vectors++;
      if (note_code !== 7'd0 || step_idx !== '0) begin
         miscompares++;
         $display("FAIL rstmid_code got %0d/%0d want 0/0", note_code, step_idx);
      end
      start_at = -1;
      rst_at   = -1;
      done_at  = -1;
      mdl_note = 7'd0;
      play(1, 1'b0, 3, 0, -1);
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL rstmid_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rstmid_ev%0d got k%0d c%0d n%0d want k%0d c%0d n%0d",
                     i, act_q[i].k, act_q[i].c, act_q[i].n,
                     exp_q[i].k, exp_q[i].c, exp_q[i].n);
         end
      end
   endtask

   task automatic test_edges();
      play(0, 1'b0, 2, 0, -1);
      vectors++;
      if (act_q.size() !== 0 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL len0 got %0d events run %b want 0 run 0", act_q.size(), running);
      end
      write_entry(0, 70, 3);
      write_entry(1, 72, 2);
      pend_a = '0;
      pend_n = 7'd75;
      pend_d = DURW'(3);
      wr_at  = cyc + 2;
      play(2, 1'b1, 2, 0, 40);
      mdl_pn[0] = 7'd75;
      vectors++;
      if (act_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL wrtrig_count got %0d want %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         vectors++;
         if (act_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL wrtrig_ev%0d got k%0d c%0d n%0d want k%0d c%0d n%0d",
                     i, act_q[i].k, act_q[i].c, act_q[i].n,
                     exp_q[i].k, exp_q[i].c, exp_q[i].n);
         end
      end
      if (act_q.size() >= 5) begin
         vectors++;
         if (act_q[0].n !== 7'd70 || act_q[4].n !== 7'd75) begin
            miscompares++;
            $display("FAIL wrtrig_notes got %0d,%0d want 70,75", act_q[0].n, act_q[4].n);
         end
      end
   endtask

   task automatic test_random();
      int l, so, d;
      bit lp;
      for (int it = 0; it < 24; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            write_entry(a, int'($urandom_range(0, 127)), d);
         end
         l  = int'($urandom_range(0, DEPTH));
         lp = 1'($urandom_range(0, 1));
         if (lp) so = int'($urandom_range(1, 120));
         else so = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 80)) : -1;
         play(l, lp, int'($urandom_range(1, 4)), int'($urandom_range(0, 4)), so);
         vectors++;
         if (act_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand%0d_count got %0d want %0d", it, act_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL rand%0d_ev%0d got k%0d c%0d n%0d s%0d want k%0d c%0d n%0d s%0d",
                        it, i, act_q[i].k, act_q[i].c, act_q[i].n, act_q[i].s,
                        exp_q[i].k, exp_q[i].c, exp_q[i].n, exp_q[i].s);
            end
         end
         vectors++;
         if (running !== 1'b0) begin
            miscompares++;
            $display("FAIL rand%0d_run got %b want 0", it, running);
         end
      end
   endtask

   initial begin
      rst_b    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_note  = '0;
      wr_dur   = '0;
      len      = '0;
      loop_en  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      env_busy = 1'b0;
      env_done = 1'b0;
      mdl_note = 7'd0;
      test_reset();
      test_basic();
      test_busy();
      test_rest_loop();
      test_stop_gate();
      test_reset_mid();
      test_edges();
      test_random();
      vectors++;
      if (overlap !== 0) begin
         miscompares++;
         $display("FAIL on_off_overlap got %0d want 0", overlap);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
